// File: rtl/seq_shift_add_mult_if.sv
// Operand and product handshake bundle for seq_shift_add_mult.
// The master drives operands and out_ready. The slave is the multiplier.
interface seq_shift_add_mult_if #(
  parameter int unsigned WIDTH = 8
);
  logic               in_valid;
  logic               in_ready;
  logic               in_signed;
  logic [WIDTH-1:0]   in_a;
  logic [WIDTH-1:0]   in_b;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] out_product;

  modport master (
    output in_valid, in_signed, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_product
  );

  modport slave (
    input  in_valid, in_signed, in_a, in_b, out_ready,
    output in_ready, out_valid, out_product
  );
endinterface

// File: rtl/seq_shift_add_mult.sv
// Sequential shift-and-add multiplier that forms one partial product per clock.
// It supports unsigned or signed operands per transaction, with a fixed WIDTH+1 cycle latency.
module seq_shift_add_mult #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  seq_shift_add_mult_if.slave  bus,
  output logic                 busy
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned PW = 2 * WIDTH;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e          state_q, state_d;
  logic [WIDTH-1:0] a_sh_q;
  logic [PW-1:0]    b_sh_q;
  logic [PW-1:0]    acc_q;
  logic [CW-1:0]    count_q;
  logic [PW-1:0]    product_q;
  logic             sign_q;
  logic             rst_q;

  logic             accept;
  logic             last;
  logic             in_ready_w;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [PW-1:0]    acc_next;
  logic [PW-1:0]    prod_next;

  // rst_q keeps in_ready low in the cycle after a reset edge without an input-to-output path.
  always_ff @(posedge clk) begin
    rst_q <= rst;
  end

  assign accept = bus.in_valid && in_ready_w;
  assign last   = (count_q == CW'(WIDTH - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StRun;
      StRun:   if (last) state_d = StDone;
      StDone:  if (bus.out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs are decoded from registered state only.
  always_comb begin
    in_ready_w    = (state_q == StIdle) && !rst_q;
    bus.in_ready  = in_ready_w;
    bus.out_valid = (state_q == StDone);
    busy          = (state_q == StRun) || (state_q == StDone);
  end

  assign bus.out_product = product_q;

  // The magnitude of -2^(WIDTH-1) wraps to 2^(WIDTH-1), which is still correct as unsigned.
  always_comb begin
    a_mag     = (bus.in_signed && bus.in_a[WIDTH-1]) ? -bus.in_a : bus.in_a;
    b_mag     = (bus.in_signed && bus.in_b[WIDTH-1]) ? -bus.in_b : bus.in_b;
    acc_next  = a_sh_q[0] ? (acc_q + b_sh_q) : acc_q;
    prod_next = sign_q ? -acc_next : acc_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh_q    <= '0;
      b_sh_q    <= '0;
      acc_q     <= '0;
      count_q   <= '0;
      product_q <= '0;
      sign_q    <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            sign_q  <= bus.in_signed & (bus.in_a[WIDTH-1] ^ bus.in_b[WIDTH-1]);
            a_sh_q  <= a_mag;
            b_sh_q  <= {{WIDTH{1'b0}}, b_mag};
            acc_q   <= '0;
            count_q <= '0;
          end
        end
        StRun: begin
          acc_q   <= acc_next;
          a_sh_q  <= a_sh_q >> 1;
          b_sh_q  <= b_sh_q << 1;
          count_q <= count_q + CW'(1);
          if (last) begin
            product_q <= prod_next;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_shift_add_mult.sv
// Directed bench for seq_shift_add_mult at WIDTH=8 and WIDTH=16.
// It checks latency, the hold behaviour while the consumer stalls, and mid-transaction reset.
module tb_seq_shift_add_mult;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy8, busy16;
  int   cyc = 0;
  int   n_assert = 0;
  int   n_fail = 0;
  int   last_accept = 0;
  int   first_accept = 0;
  int   seen = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  seq_shift_add_mult_if #(.WIDTH(8))  bus8 ();
  seq_shift_add_mult_if #(.WIDTH(16)) bus16 ();

  seq_shift_add_mult #(.WIDTH(8)) dut8 (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus8),
    .busy (busy8)
  );

  seq_shift_add_mult #(.WIDTH(16)) dut16 (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus16),
    .busy (busy16)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One 8-bit transaction with out_ready high, checking exact latency.
  task automatic run8(input string tag, input logic sg, input logic [7:0] a, input logic [7:0] b,
                      input logic [15:0] exp);
    int n = 0;
    bus8.out_ready = 1'b1;
    while (bus8.in_ready !== 1'b1 && n < 30) begin
      step();
      n++;
    end
    chk({tag, "_in_ready"}, 32'(bus8.in_ready), 32'd1);
    bus8.in_valid  = 1'b1;
    bus8.in_signed = sg;
    bus8.in_a      = a;
    bus8.in_b      = b;
    last_accept    = cyc;
    step();
    bus8.in_valid  = 1'b0;
    bus8.in_signed = ~sg;
    bus8.in_a      = ~a;
    bus8.in_b      = ~b;
    chk({tag, "_busy"}, 32'(busy8), 32'd1);
    chk({tag, "_rdy_run"}, 32'(bus8.in_ready), 32'd0);
    repeat (7) step();
    chk({tag, "_early"}, 32'(bus8.out_valid), 32'd0);
    step();
    chk({tag, "_valid"}, 32'(bus8.out_valid), 32'd1);
    chk({tag, "_prod"}, 32'(bus8.out_product), 32'(exp));
    step();
    chk({tag, "_drop"}, 32'(bus8.out_valid), 32'd0);
    chk({tag, "_rdy_back"}, 32'(bus8.in_ready), 32'd1);
  endtask

  task automatic run16(input string tag, input logic sg, input logic [15:0] a,
                       input logic [15:0] b, input logic [31:0] exp);
    int n = 0;
    bus16.out_ready = 1'b1;
    while (bus16.in_ready !== 1'b1 && n < 30) begin
      step();
      n++;
    end
    chk({tag, "_in_ready"}, 32'(bus16.in_ready), 32'd1);
    bus16.in_valid  = 1'b1;
    bus16.in_signed = sg;
    bus16.in_a      = a;
    bus16.in_b      = b;
    step();
    bus16.in_valid  = 1'b0;
    repeat (15) step();
    chk({tag, "_early"}, 32'(bus16.out_valid), 32'd0);
    step();
    chk({tag, "_valid"}, 32'(bus16.out_valid), 32'd1);
    chk({tag, "_prod"}, bus16.out_product, exp);
    step();
    chk({tag, "_drop"}, 32'(bus16.out_valid), 32'd0);
  endtask

  initial begin
    bus8.in_valid   = 1'b0;
    bus8.in_signed  = 1'b0;
    bus8.in_a       = '0;
    bus8.in_b       = '0;
    bus8.out_ready  = 1'b1;
    bus16.in_valid  = 1'b0;
    bus16.in_signed = 1'b0;
    bus16.in_a      = '0;
    bus16.in_b      = '0;
    bus16.out_ready = 1'b1;

    // Reset state.
    step();
    step();
    chk("rst_in_ready", 32'(bus8.in_ready), 32'd0);
    chk("rst_out_valid", 32'(bus8.out_valid), 32'd0);
    chk("rst_busy", 32'(busy8), 32'd0);
    chk("rst_prod", 32'(bus8.out_product), 32'd0);
    rst = 1'b0;
    step();
    chk("post_rst_ready", 32'(bus8.in_ready), 32'd1);
    chk("post_rst_prod", 32'(bus8.out_product), 32'd0);

    // Unsigned and signed products.
    run8("u_ff_ff", 1'b0, 8'hFF, 8'hFF, 16'hFE01);
    run8("s_m128_m128", 1'b1, 8'h80, 8'h80, 16'h4000);
    run8("s_m128_127", 1'b1, 8'h80, 8'h7F, 16'hC080);
    run8("s_m1_1", 1'b1, 8'hFF, 8'h01, 16'hFFFF);
    run8("s_5_m3", 1'b1, 8'h05, 8'hFD, 16'hFFF1);
    run8("u_ff_01", 1'b0, 8'hFF, 8'h01, 16'h00FF);

    // Zero operand followed by back-to-back accepts.
    run8("u_0_200", 1'b0, 8'h00, 8'hC8, 16'h0000);
    first_accept = last_accept;
    run8("u_b2b", 1'b0, 8'h03, 8'h05, 16'h000F);
    chk("b2b_interval", 32'(last_accept - first_accept), 32'd10);

    // The consumer stalls for 5 cycles while new operands are offered.
    bus8.out_ready = 1'b0;
    chk("hold_in_ready", 32'(bus8.in_ready), 32'd1);
    bus8.in_valid  = 1'b1;
    bus8.in_signed = 1'b0;
    bus8.in_a      = 8'h80;
    bus8.in_b      = 8'hFF;
    step();
    bus8.in_valid = 1'b0;
    repeat (8) step();
    for (int i = 0; i < 5; i++) begin
      bus8.in_valid = 1'b1;
      bus8.in_a     = 8'h01;
      bus8.in_b     = 8'h01;
      chk("hold_valid", 32'(bus8.out_valid), 32'd1);
      chk("hold_prod", 32'(bus8.out_product), 32'h7F80);
      chk("hold_no_ready", 32'(bus8.in_ready), 32'd0);
      step();
    end
    bus8.in_valid  = 1'b0;
    bus8.out_ready = 1'b1;
    chk("hold_last_valid", 32'(bus8.out_valid), 32'd1);
    step();
    chk("hold_released", 32'(bus8.out_valid), 32'd0);
    chk("hold_ready_back", 32'(bus8.in_ready), 32'd1);
    seen = 0;
    repeat (12) begin
      step();
      seen += int'(bus8.out_valid);
    end
    chk("hold_no_second", 32'(seen), 32'd0);
    chk("hold_idle_busy", 32'(busy8), 32'd0);

    // Reset in RUN cycle c+4 discards the transaction.
    bus8.in_valid = 1'b1;
    bus8.in_a     = 8'h0F;
    bus8.in_b     = 8'h0F;
    step();
    bus8.in_valid = 1'b0;
    repeat (3) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_valid", 32'(bus8.out_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy8), 32'd0);
    chk("mid_rst_prod", 32'(bus8.out_product), 32'd0);
    chk("mid_rst_ready", 32'(bus8.in_ready), 32'd0);
    seen = 0;
    repeat (12) begin
      step();
      seen += int'(bus8.out_valid);
    end
    chk("mid_rst_no_out", 32'(seen), 32'd0);
    run8("u_3_7", 1'b0, 8'h03, 8'h07, 16'd21);

    // Wider operands.
    run16("u16_ffff", 1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001);
    run16("s16_8000", 1'b1, 16'h8000, 16'h8000, 32'h40000000);
    run16("s16_m2_3", 1'b1, 16'hFFFE, 16'h0003, 32'hFFFFFFFA);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
